rcc_hse_css_monitor: RTL and testbench



---
 rtl/rcc_hse_css_monitor.sv | 97 +++++++++
 tb/tb_rcc_hse_css_monitor.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rcc_hse_css_monitor.sv
// HSE clock security system detector: flags a stalled, already-synchronised HSE toggle.
module rcc_hse_css_monitor #(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned ARM_EDGES   = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       css_en,
  input  logic       hse_rdy,
  input  logic       hse_tick,
  input  logic       css_clr,
  output logic       hsecss_fail,
  output logic       hsecss_fail_pulse,
  output logic       css_active,
  output logic [1:0] css_state
);

  localparam int unsigned        ECNT_W   = $clog2(ARM_EDGES + 1);
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [ECNT_W-1:0] ARM_LAST = ECNT_W'(ARM_EDGES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ARM  = 2'b01,
    MON  = 2'b10,
    FAIL = 2'b11
  } state_t;

  state_t              state;
  state_t              state_n;
  logic                tick_d;
  logic                tick_edge;
  logic                hse_ok;
  logic                timeout;
  logic [CNT_W-1:0]    gap_cnt;
  logic [CNT_W-1:0]    gap_cnt_n;
  logic [ECNT_W-1:0]   edge_cnt;
  logic [ECNT_W-1:0]   edge_cnt_n;

  assign tick_edge = hse_tick ^ tick_d;
  assign hse_ok    = css_en & hse_rdy;
  // An edge in the would-be timeout cycle suppresses the timeout.
  assign timeout   = !tick_edge && (gap_cnt == TMO_LAST);

  // Next-state decision.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (hse_ok) state_n = ARM;
      ARM: begin
        if (!hse_ok)                                   state_n = IDLE;
        else if (tick_edge && (edge_cnt == ARM_LAST))  state_n = MON;
        else if (timeout)                              state_n = FAIL;
      end
      MON: begin
        if (!hse_ok)      state_n = IDLE;
        else if (timeout) state_n = FAIL;
      end
      FAIL: if (css_clr) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Gap timer and arming edge counter updates.
  always_comb begin
    gap_cnt_n  = '0;
    edge_cnt_n = '0;
    if (!tick_edge && ((state == ARM) || (state == MON)))
      gap_cnt_n = gap_cnt + 1'b1;
    if (state == ARM)
      edge_cnt_n = tick_edge ? edge_cnt + 1'b1 : edge_cnt;
  end

  // State, counters and registered failure outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      tick_d            <= 1'b0;
      gap_cnt           <= '0;
      edge_cnt          <= '0;
      hsecss_fail       <= 1'b0;
      hsecss_fail_pulse <= 1'b0;
    end else begin
      state             <= state_n;
      tick_d            <= hse_tick;
      gap_cnt           <= gap_cnt_n;
      edge_cnt          <= edge_cnt_n;
      hsecss_fail       <= (state_n == FAIL);
      hsecss_fail_pulse <= (state_n == FAIL) && (state != FAIL);
    end
  end

  assign css_state  = state;
  assign css_active = (state == ARM) || (state == MON);

endmodule

// File: tb/tb_rcc_hse_css_monitor.sv
// Directed bench for rcc_hse_css_monitor with TIMEOUT_CYC=64, ARM_EDGES=4.
module tb_rcc_hse_css_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       css_en;
  logic       hse_rdy;
  logic       hse_tick;
  logic       css_clr;
  logic       hsecss_fail;
  logic       hsecss_fail_pulse;
  logic       css_active;
  logic [1:0] css_state;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // {css_state, css_active, hsecss_fail, hsecss_fail_pulse}
  logic [4:0] obs;
  assign obs = {css_state, css_active, hsecss_fail, hsecss_fail_pulse};

  localparam logic [4:0] O_IDLE  = 5'b00_0_0_0;
  localparam logic [4:0] O_ARM   = 5'b01_1_0_0;
  localparam logic [4:0] O_MON   = 5'b10_1_0_0;
  localparam logic [4:0] O_FENT  = 5'b11_0_1_1;
  localparam logic [4:0] O_FHOLD = 5'b11_0_1_0;

  rcc_hse_css_monitor #(
    .TIMEOUT_CYC(64),
    .ARM_EDGES  (4),
    .CNT_W      (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .css_en           (css_en),
    .hse_rdy          (hse_rdy),
    .hse_tick         (hse_tick),
    .css_clr          (css_clr),
    .hsecss_fail      (hsecss_fail),
    .hsecss_fail_pulse(hsecss_fail_pulse),
    .css_active       (css_active),
    .css_state        (css_state)
  );

  always #5 clk = ~clk;

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic toggle_and_step();
    hse_tick = ~hse_tick;
    step(1);
  endtask

  // Four edges spaced 5 cycles apart, starting from ARM; ends on the last edge cycle.
  task automatic arm_to_mon();
    for (int unsigned i = 0; i < 4; i++) begin
      step(4);
      toggle_and_step();
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    css_en   = 1'($urandom);
    hse_rdy  = 1'($urandom);
    hse_tick = 1'($urandom);
    css_clr  = 1'($urandom);
    #3;
    vectors++;
    if (obs !== O_IDLE) begin
      miscompares++;
      $display("FAIL reset_async: got %b want %b", obs, O_IDLE);
    end
    step(3);
    vectors++;
    if (obs !== O_IDLE) begin
      miscompares++;
      $display("FAIL reset_held: got %b want %b", obs, O_IDLE);
    end
    css_en   = 1'b1;
    hse_rdy  = 1'b1;
    hse_tick = 1'b0;
    css_clr  = 1'b0;
    rst      = 1'b0;
    step(1);
    vectors++;
    if (obs !== O_ARM) begin
      miscompares++;
      $display("FAIL reset_release_arm: got %b want %b", obs, O_ARM);
    end
  endtask

  task automatic test_healthy();
    for (int unsigned i = 0; i < 4; i++) begin
      step(9);
      toggle_and_step();
      vectors++;
      if (obs !== ((i == 3) ? O_MON : O_ARM)) begin
        miscompares++;
        $display("FAIL healthy_arm_edge%0d: got %b want %b", i, obs, (i == 3) ? O_MON : O_ARM);
      end
    end
    for (int unsigned g = 0; g < 200; g++) begin
      step(9);
      toggle_and_step();
      vectors++;
      if (obs !== O_MON) begin
        miscompares++;
        $display("FAIL healthy_gap%0d: got %b want %b", g, obs, O_MON);
      end
    end
  endtask

  task automatic test_stopped();
    step(63);
    vectors++;
    if (obs !== O_MON) begin
      miscompares++;
      $display("FAIL stopped_before_timeout: got %b want %b", obs, O_MON);
    end
    step(1);
    vectors++;
    if (obs !== O_FENT) begin
      miscompares++;
      $display("FAIL stopped_fail_entry: got %b want %b", obs, O_FENT);
    end
    step(1);
    vectors++;
    if (obs !== O_FHOLD) begin
      miscompares++;
      $display("FAIL stopped_pulse_width: got %b want %b", obs, O_FHOLD);
    end
    css_clr = 1'b1;
    step(1);
    css_clr = 1'b0;
    vectors++;
    if (obs !== O_IDLE) begin
      miscompares++;
      $display("FAIL stopped_clear: got %b want %b", obs, O_IDLE);
    end
    step(1);
    vectors++;
    if (obs !== O_ARM) begin
      miscompares++;
      $display("FAIL stopped_rearm: got %b want %b", obs, O_ARM);
    end
  endtask

  task automatic test_boundary();
    arm_to_mon();
    vectors++;
    if (obs !== O_MON) begin
      miscompares++;
      $display("FAIL boundary_enter_mon: got %b want %b", obs, O_MON);
    end
    for (int unsigned g = 0; g < 50; g++) begin
      step(63);
      toggle_and_step();
      vectors++;
      if (obs !== O_MON) begin
        miscompares++;
        $display("FAIL boundary_gap64_%0d: got %b want %b", g, obs, O_MON);
      end
    end
    step(63);
    vectors++;
    if (obs !== O_MON) begin
      miscompares++;
      $display("FAIL boundary_gap65_pre: got %b want %b", obs, O_MON);
    end
    step(1);
    vectors++;
    if (obs !== O_FENT) begin
      miscompares++;
      $display("FAIL boundary_gap65_fail: got %b want %b", obs, O_FENT);
    end
    css_clr = 1'b1;
    step(1);
    css_clr = 1'b0;
    step(1);
    vectors++;
    if (obs !== O_ARM) begin
      miscompares++;
      $display("FAIL boundary_rearm: got %b want %b", obs, O_ARM);
    end
  endtask

  task automatic test_enable_and_clear();
    arm_to_mon();
    step(5);
    css_en = 1'b0;
    step(1);
    vectors++;
    if (obs !== O_IDLE) begin
      miscompares++;
      $display("FAIL en_drop_mon_idle: got %b want %b", obs, O_IDLE);
    end
    step(3);
    vectors++;
    if (obs !== O_IDLE) begin
      miscompares++;
      $display("FAIL en_drop_stay_idle: got %b want %b", obs, O_IDLE);
    end
    css_en = 1'b1;
    step(1);
    vectors++;
    if (obs !== O_ARM) begin
      miscompares++;
      $display("FAIL en_restore_arm: got %b want %b", obs, O_ARM);
    end
    arm_to_mon();
    step(64);
    vectors++;
    if (obs !== O_FENT) begin
      miscompares++;
      $display("FAIL en_fail_entry: got %b want %b", obs, O_FENT);
    end
    css_en  = 1'b0;
    hse_rdy = 1'b0;
    step(3);
    vectors++;
    if (obs !== O_FHOLD) begin
      miscompares++;
      $display("FAIL en_drop_in_fail: got %b want %b", obs, O_FHOLD);
    end
    css_en  = 1'b1;
    hse_rdy = 1'b1;
    css_clr = 1'b1;
    step(1);
    css_clr = 1'b0;
    step(1);
    arm_to_mon();
    css_clr = 1'b1;
    step(1);
    css_clr = 1'b0;
    vectors++;
    if (obs !== O_MON) begin
      miscompares++;
      $display("FAIL clr_in_mon_ignored: got %b want %b", obs, O_MON);
    end
    step(62);
    css_clr = 1'b1;
    step(1);
    css_clr = 1'b0;
    vectors++;
    if (obs !== O_FENT) begin
      miscompares++;
      $display("FAIL clr_at_entry: got %b want %b", obs, O_FENT);
    end
    step(1);
    vectors++;
    if (obs !== O_FHOLD) begin
      miscompares++;
      $display("FAIL clr_at_entry_sticky: got %b want %b", obs, O_FHOLD);
    end
    css_clr = 1'b1;
    step(1);
    css_clr = 1'b0;
    vectors++;
    if (obs !== O_IDLE) begin
      miscompares++;
      $display("FAIL clr_exit: got %b want %b", obs, O_IDLE);
    end
  endtask

  task automatic test_arm_fail_and_reset();
    step(1);
    vectors++;
    if (obs !== O_ARM) begin
      miscompares++;
      $display("FAIL armfail_enter_arm: got %b want %b", obs, O_ARM);
    end
    step(63);
    vectors++;
    if (obs !== O_ARM) begin
      miscompares++;
      $display("FAIL armfail_before_timeout: got %b want %b", obs, O_ARM);
    end
    step(1);
    vectors++;
    if (obs !== O_FENT) begin
      miscompares++;
      $display("FAIL armfail_entry: got %b want %b", obs, O_FENT);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (obs !== O_IDLE) begin
      miscompares++;
      $display("FAIL async_reset_in_fail: got %b want %b", obs, O_IDLE);
    end
    step(1);
    rst = 1'b0;
    step(1);
    vectors++;
    if (obs !== O_ARM) begin
      miscompares++;
      $display("FAIL post_reset_arm: got %b want %b", obs, O_ARM);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_healthy();
    test_stopped();
    test_boundary();
    test_enable_and_clear();
    test_arm_fail_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
